pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the five inter-stage registers (pc, if_id1, id1_id2, id2_ex, ex_mem).

---
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the five inter-stage registers: load-use hazards,
// multi-cycle mul/div sequencing in EX, bus wait states and MEM redirects.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id2_rs,
    input  logic [4:0] id2_rt,
    input  logic       id2_rs_rd,
    input  logic       id2_rt_rd,
    input  logic       ex_is_load,
    input  logic [4:0] ex_w_reg_dst,
    input  logic       ex_md_start,
    input  logic       ex_md_is_div,
    input  logic       ibus_stall,
    input  logic       dbus_stall,
    input  logic       mem_exc,
    output logic       stall_pc,
    output logic       stall_if_id1,
    output logic       stall_id1_id2,
    output logic       stall_id2_ex,
    output logic       stall_ex_mem,
    output logic       flush_if_id1,
    output logic       flush_id1_id2,
    output logic       flush_id2_ex,
    output logic       flush_ex_mem,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_abort
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;
    logic             load_use;
    logic             md_hold;

    assign load_use = ex_is_load && (ex_w_reg_dst != 5'd0) &&
                      ((id2_rs_rd && (id2_rs == ex_w_reg_dst)) ||
                       (id2_rt_rd && (id2_rt == ex_w_reg_dst)));

    // The start cycle itself already stalls, so IDLE with a pending op counts as busy.
    assign md_hold  = (state_q == MD_BUSY) || ((state_q == MD_IDLE) && ex_md_start);
    assign load_val = ex_md_is_div ? DIV_LOAD : MUL_LOAD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (ex_md_start && !mem_exc && !dbus_stall) begin
                    cnt_d   = load_val;
                    state_d = (load_val == '0) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (mem_exc) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                // Stay here while EX is held so the same op is not re-issued.
                if (!stall_id2_ex || mem_exc) state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id1  = 1'b0;
        stall_id1_id2 = 1'b0;
        stall_id2_ex  = 1'b0;
        stall_ex_mem  = 1'b0;
        flush_if_id1  = 1'b0;
        flush_id1_id2 = 1'b0;
        flush_id2_ex  = 1'b0;
        flush_ex_mem  = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        md_abort      = 1'b0;
        if (!rst) begin
            if (mem_exc) begin
                flush_if_id1  = 1'b1;
                flush_id1_id2 = 1'b1;
                flush_id2_ex  = 1'b1;
                flush_ex_mem  = 1'b1;
            end else if (dbus_stall) begin
                stall_pc      = 1'b1;
                stall_if_id1  = 1'b1;
                stall_id1_id2 = 1'b1;
                stall_id2_ex  = 1'b1;
                stall_ex_mem  = 1'b1;
            end else if (md_hold) begin
                stall_pc      = 1'b1;
                stall_if_id1  = 1'b1;
                stall_id1_id2 = 1'b1;
                stall_id2_ex  = 1'b1;
                flush_ex_mem  = 1'b1;
            end else if (load_use) begin
                stall_pc      = 1'b1;
                stall_if_id1  = 1'b1;
                stall_id1_id2 = 1'b1;
                flush_id2_ex  = 1'b1;
            end else if (ibus_stall) begin
                stall_pc      = 1'b1;
                flush_if_id1  = 1'b1;
            end
            md_busy  = (state_q == MD_BUSY);
            md_done  = (state_q == MD_DONE);
            md_abort = (state_q == MD_BUSY) && mem_exc;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: priority table in IDLE plus mul/div, abort and
// DONE-hold sequences, all checked through an expected-value queue.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id2_rs, id2_rt, ex_w_reg_dst;
    logic       id2_rs_rd, id2_rt_rd, ex_is_load, ex_md_start, ex_md_is_div;
    logic       ibus_stall, dbus_stall, mem_exc;
    logic       stall_pc, stall_if_id1, stall_id1_id2, stall_id2_ex, stall_ex_mem;
    logic       flush_if_id1, flush_id1_id2, flush_id2_ex, flush_ex_mem;
    logic       md_busy, md_done, md_abort;
    logic [11:0] act;

    // {stall pc,if_id1,id1_id2,id2_ex,ex_mem | flush if_id1,id1_id2,id2_ex,ex_mem | busy,done,abort}
    localparam logic [11:0] O_NONE = 12'b00000_0000_000;
    localparam logic [11:0] O_EXC  = 12'b00000_1111_000;
    localparam logic [11:0] O_DBUS = 12'b11111_0000_000;
    localparam logic [11:0] O_MD   = 12'b11110_0001_000;
    localparam logic [11:0] O_LU   = 12'b11100_0010_000;
    localparam logic [11:0] O_IBUS = 12'b10000_1000_000;
    localparam logic [11:0] B_BUSY = 12'b00000_0000_100;
    localparam logic [11:0] B_DONE = 12'b00000_0000_010;
    localparam logic [11:0] B_ABRT = 12'b00000_0000_001;

    typedef struct {
        logic [4:0]  rs, rt, dst;
        logic        rs_rd, rt_rd, is_load, md_start, md_div, ibus, dbus, exc;
        logic [11:0] exp;
    } vec_t;

    logic [11:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    vec_t        tbl[$];

    pipe_hazard_ctrl #(.MUL_CYCLES(3), .DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id2_rs(id2_rs), .id2_rt(id2_rt), .id2_rs_rd(id2_rs_rd), .id2_rt_rd(id2_rt_rd),
        .ex_is_load(ex_is_load), .ex_w_reg_dst(ex_w_reg_dst),
        .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div),
        .ibus_stall(ibus_stall), .dbus_stall(dbus_stall), .mem_exc(mem_exc),
        .stall_pc(stall_pc), .stall_if_id1(stall_if_id1), .stall_id1_id2(stall_id1_id2),
        .stall_id2_ex(stall_id2_ex), .stall_ex_mem(stall_ex_mem),
        .flush_if_id1(flush_if_id1), .flush_id1_id2(flush_id1_id2),
        .flush_id2_ex(flush_id2_ex), .flush_ex_mem(flush_ex_mem),
        .md_busy(md_busy), .md_done(md_done), .md_abort(md_abort)
    );

    assign act = {stall_pc, stall_if_id1, stall_id1_id2, stall_id2_ex, stall_ex_mem,
                  flush_if_id1, flush_id1_id2, flush_id2_ex, flush_ex_mem,
                  md_busy, md_done, md_abort};

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic rs_rd, input logic rt_rd,
                                input logic is_load, input logic [4:0] dst,
                                input logic md_start, input logic md_div,
                                input logic ibus, input logic dbus, input logic exc,
                                input logic [11:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rs_rd = rs_rd; v.rt_rd = rt_rd;
        v.is_load = is_load; v.dst = dst; v.md_start = md_start; v.md_div = md_div;
        v.ibus = ibus; v.dbus = dbus; v.exc = exc; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t md(input logic start, input logic div, input logic dbus,
                                input logic exc, input logic [11:0] exp);
        return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, start, div, 1'b0, dbus, exc, exp);
    endfunction

    task automatic drive(input vec_t v);
        id2_rs = v.rs; id2_rt = v.rt; id2_rs_rd = v.rs_rd; id2_rt_rd = v.rt_rd;
        ex_is_load = v.is_load; ex_w_reg_dst = v.dst;
        ex_md_start = v.md_start; ex_md_is_div = v.md_div;
        ibus_stall = v.ibus; dbus_stall = v.dbus; mem_exc = v.exc;
    endtask

    task automatic check_out(input string name);
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %b but no expected value queued", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", name, act, e);
            end
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Drive one cycle's inputs after the edge, compare on the falling edge.
    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v.exp);
        @(negedge clk);
        check_out(name);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int busy_n, done_n, fem_n, hold_n;
        rst = 1'b1;
        drive(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        repeat (2) @(posedge clk);

        // Outputs must stay quiet while reset is held, whatever the inputs.
        #1;
        drive(mk(5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_NONE));
        exp_q.push_back(O_NONE);
        @(negedge clk);
        check_out("during_reset");

        tbl.push_back(mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        tbl.push_back(mk(5'd3,  5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(5'd5,  5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(5'd5,  5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        tbl.push_back(mk(5'd0,  5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        tbl.push_back(mk(5'd3,  5'd3, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        tbl.push_back(mk(5'd19, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE));
        tbl.push_back(mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IBUS));
        tbl.push_back(mk(5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_LU));
        tbl.push_back(mk(5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, O_DBUS));
        tbl.push_back(mk(5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_EXC));
        tbl.push_back(mk(5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_MD));
        tbl.push_back(mk(5'd9,  5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_DBUS));
        tbl.push_back(mk(5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_EXC));
        tbl.push_back(mk(5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU));
        foreach (tbl[i]) begin
            do_reset();
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Load-use resolves after one bubble.
        do_reset();
        apply(mk(5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_LU), "lu_cycle1");
        apply(mk(5'd3, 5'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE), "lu_cycle2");

        // Full divide: start + 32 BUSY stalled, then DONE unstalled.
        do_reset();
        busy_n = 0; done_n = 0; fem_n = 0; hold_n = 0;
        for (int i = 0; i < 34; i++) begin
            if (i == 0)       apply(md(1'b1, 1'b1, 1'b0, 1'b0, O_MD), "div_start");
            else if (i < 33)  apply(md(1'b1, 1'b1, 1'b0, 1'b0, O_MD | B_BUSY), $sformatf("div_busy%0d", i));
            else              apply(md(1'b1, 1'b1, 1'b0, 1'b0, B_DONE), "div_done");
            busy_n += int'(md_busy);
            done_n += int'(md_done);
            fem_n  += int'(flush_ex_mem);
            hold_n += int'(stall_id2_ex);
        end
        apply(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE), "div_after");
        chk_int("div_busy_cycles", busy_n, 32);
        chk_int("div_done_cycles", done_n, 1);
        chk_int("div_flush_ex_mem_cycles", fem_n, 33);
        chk_int("div_ex_occupancy", hold_n + 1, 34);

        // Exception on the 5th BUSY cycle aborts the divide.
        do_reset();
        apply(md(1'b1, 1'b1, 1'b0, 1'b0, O_MD), "abort_start");
        for (int i = 1; i <= 4; i++)
            apply(md(1'b1, 1'b1, 1'b0, 1'b0, O_MD | B_BUSY), $sformatf("abort_busy%0d", i));
        apply(md(1'b1, 1'b1, 1'b0, 1'b1, O_EXC | B_BUSY | B_ABRT), "abort_exc");
        apply(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE), "abort_idle");

        // Multiply reaching DONE while dbus stalls for 3 cycles.
        do_reset();
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD), "mul_start");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD | B_BUSY), "mul_busy1");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD | B_BUSY), "mul_busy2");
        for (int i = 0; i < 3; i++)
            apply(md(1'b1, 1'b0, 1'b1, 1'b0, O_DBUS | B_DONE), $sformatf("mul_done_dbus%0d", i));
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, B_DONE), "mul_done_release");
        apply(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE), "mul_idle");

        // Start blocked by dbus, then proceeds once the bus frees.
        do_reset();
        apply(md(1'b1, 1'b0, 1'b1, 1'b0, O_DBUS), "start_dbus");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD), "start_after_dbus");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD | B_BUSY), "busy_after_dbus");

        // Exception during DONE flushes but is not an abort.
        do_reset();
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD), "done_exc_start");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD | B_BUSY), "done_exc_busy1");
        apply(md(1'b1, 1'b0, 1'b0, 1'b0, O_MD | B_BUSY), "done_exc_busy2");
        apply(md(1'b1, 1'b0, 1'b0, 1'b1, O_EXC | B_DONE), "done_exc");
        apply(md(1'b0, 1'b0, 1'b0, 1'b0, O_NONE), "done_exc_idle");

        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
